// File: rtl/recurrence_pkg.sv
`default_nettype none
// ============================================================================
// Module      : recurrence_pkg
// Description : Shared definitions for the recurrence sequencer. Holds the FSM
//               state encoding, the per-step arithmetic constants and the
//               default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package recurrence_pkg;

    // Default operand width for a, b, c, d
    localparam int c_DEFAULT_WIDTH = 32;

    // Step constants: d = a - 3, b = d + 10, c = c + 1
    localparam int c_STEP_D_SUB = 3;
    localparam int c_STEP_B_ADD = 10;
    localparam int c_STEP_C_INC = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STEP_A = 3'd2,
        ST_STEP_D = 3'd3,
        ST_STEP_B = 3'd4,
        ST_STEP_C = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

endpackage : recurrence_pkg
`default_nettype wire

// File: rtl/seq_delay_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_delay_timer
// Description : Down-counter that paces the sequencer between step updates.
//               A load reloads the count; while enabled it counts down and
//               raises tick in the last waiting cycle.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               load   - reload the count (asserted on every WAIT entry)
//               enable - high while the sequencer sits in WAIT
//               tick   - last WAIT cycle; the sequencer leaves WAIT on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module seq_delay_timer #(
    parameter int DELAY = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(DELAY + 1);

    // The step state itself consumes one cycle of each DELAY-cycle interval,
    // so WAIT only has to cover the remaining DELAY-1 cycles.
    localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(DELAY - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_LOAD;
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign tick = enable && (r_cnt <= CNT_W'(1));

endmodule : seq_delay_timer
`default_nettype wire

// File: rtl/recurrence_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : recurrence_sequencer
// Description : Runs N passes of the four-step recurrence
//                   a = b + c ; d = a - 3 ; b = d + 10 ; c = c + 1
//               with one step update every DELAY cycles. Each step sees the
//               results of the earlier steps of the same pass.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               start, iterations     - begin a run of 'iterations' passes
//               a_init..d_init        - initial operand values, taken with start
//               abort                 - cancel an active run (no done)
//               a, b, c, d            - current operand values
//               busy                  - run in progress
//               done                  - one-cycle pulse on normal completion
//               iter_cnt              - completed passes of current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module recurrence_sequencer
    import recurrence_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int DELAY  = 5,
    parameter int ITER_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ITER_W-1:0]       iterations,
    input  logic signed [WIDTH-1:0] a_init,
    input  logic signed [WIDTH-1:0] b_init,
    input  logic signed [WIDTH-1:0] c_init,
    input  logic signed [WIDTH-1:0] d_init,
    output logic signed [WIDTH-1:0] a,
    output logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] c,
    output logic signed [WIDTH-1:0] d,
    output logic                    busy,
    output logic                    done,
    output logic [ITER_W-1:0]       iter_cnt
);

    // With DELAY=1 there is no spare cycle for WAIT: step states follow
    // each other back to back.
    localparam bit c_BYPASS_WAIT = (DELAY == 1);

    state_t r_state;
    state_t w_next_state;
    state_t r_pending;
    state_t w_next_pending;
    state_t w_go_step;

    logic                    w_go;
    logic                    w_accept;
    logic                    w_finish;
    logic                    w_upd_a;
    logic                    w_upd_d;
    logic                    w_upd_b;
    logic                    w_upd_c;
    logic                    w_timer_load;
    logic                    w_in_wait;
    logic                    w_tick;
    logic [ITER_W-1:0]       w_iter_next;

    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;
    logic signed [WIDTH-1:0] r_c;
    logic signed [WIDTH-1:0] r_d;
    logic [ITER_W-1:0]       r_iterations;
    logic [ITER_W-1:0]       r_iter_cnt;
    logic                    r_busy;
    logic                    r_done;

    assign w_in_wait   = (r_state == ST_WAIT);
    assign w_iter_next = r_iter_cnt + ITER_W'(1);

    seq_delay_timer #(
        .DELAY (DELAY)
    ) u_delay_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_timer_load),
        .enable (w_in_wait),
        .tick   (w_tick)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= ST_STEP_A;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_next_pending;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and step controls. Abort takes priority over the step
    // update, so a step edge coinciding with abort leaves registers alone.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_next_pending = r_pending;
        w_go           = 1'b0;
        w_go_step      = ST_STEP_A;
        w_accept       = 1'b0;
        w_finish       = 1'b0;
        w_upd_a        = 1'b0;
        w_upd_d        = 1'b0;
        w_upd_b        = 1'b0;
        w_upd_c        = 1'b0;
        w_timer_load   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (iterations == '0) begin
                        w_next_state = ST_FINISH;
                    end else begin
                        w_go      = 1'b1;
                        w_go_step = ST_STEP_A;
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_tick) begin
                    w_next_state = r_pending;
                end
            end
            ST_STEP_A: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_upd_a   = 1'b1;
                    w_go      = 1'b1;
                    w_go_step = ST_STEP_D;
                end
            end
            ST_STEP_D: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_upd_d   = 1'b1;
                    w_go      = 1'b1;
                    w_go_step = ST_STEP_B;
                end
            end
            ST_STEP_B: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_upd_b   = 1'b1;
                    w_go      = 1'b1;
                    w_go_step = ST_STEP_C;
                end
            end
            ST_STEP_C: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_upd_c = 1'b1;
                    if (w_iter_next == r_iterations) begin
                        w_next_state = ST_FINISH;
                    end else begin
                        w_go      = 1'b1;
                        w_go_step = ST_STEP_A;
                    end
                end
            end
            ST_FINISH: begin
                w_finish     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Route to the next step, through WAIT unless DELAY leaves no room.
        if (w_go) begin
            if (c_BYPASS_WAIT) begin
                w_next_state = w_go_step;
            end else begin
                w_next_state   = ST_WAIT;
                w_next_pending = w_go_step;
                w_timer_load   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_iterations <= '0;
            r_iter_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_finish;

            if (w_accept) begin
                r_a          <= a_init;
                r_b          <= b_init;
                r_c          <= c_init;
                r_d          <= d_init;
                r_iterations <= iterations;
                r_iter_cnt   <= '0;
                // A zero-pass run goes straight to FINISH and never shows busy.
                r_busy       <= (iterations != '0);
            end else if (w_next_state == ST_IDLE) begin
                r_busy <= 1'b0;
            end

            if (w_upd_a) begin
                r_a <= r_b + r_c;
            end
            if (w_upd_d) begin
                r_d <= r_a - WIDTH'(c_STEP_D_SUB);
            end
            if (w_upd_b) begin
                r_b <= r_d + WIDTH'(c_STEP_B_ADD);
            end
            if (w_upd_c) begin
                r_c        <= r_c + WIDTH'(c_STEP_C_INC);
                r_iter_cnt <= w_iter_next;
            end
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign c        = r_c;
    assign d        = r_d;
    assign busy     = r_busy;
    assign done     = r_done;
    assign iter_cnt = r_iter_cnt;

endmodule : recurrence_sequencer
`default_nettype wire

// File: tb/tb_recurrence_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_recurrence_sequencer
// Description : Self-checking bench for recurrence_sequencer. A cycle-count
//               model predicts every output of the DELAY=5 instance; directed
//               checks pin literal values, and a DELAY=1 instance is checked
//               edge by edge against a hand-computed table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recurrence_sequencer;

    localparam int D = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;
    logic abort = 1'b0;
    logic [3:0] iterations = 4'd0;
    logic signed [31:0] a_init = '0, b_init = '0, c_init = '0, d_init = '0;

    logic signed [31:0] a, b, c, d;
    logic busy, done;
    logic [3:0] iter_cnt;

    logic signed [31:0] a1, b1, c1, d1;
    logic busy1, done1;
    logic [3:0] iter1;

    int n_assert = 0;
    int n_fail = 0;
    int cur_edge = 0;

    always #5 clk = ~clk;

    recurrence_sequencer #(.WIDTH(32), .DELAY(D), .ITER_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .iterations(iterations),
        .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .done(done), .iter_cnt(iter_cnt)
    );

    recurrence_sequencer #(.WIDTH(32), .DELAY(1), .ITER_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .iterations(iterations),
        .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .iter_cnt(iter1)
    );

    // ------------------------------------------------------------------
    // Behavioural model: counts cycles since start acceptance; every D-th
    // cycle applies the next step of the pass; completion one cycle after
    // the last update.
    // ------------------------------------------------------------------
    logic signed [31:0] m_a, m_b, m_c, m_d;
    logic [3:0] m_iter;
    logic m_busy, m_done, m_run;
    int m_k, m_end;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0; m_b <= '0; m_c <= '0; m_d <= '0;
            m_iter <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_run <= 1'b0;
            m_k <= 0; m_end <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_run) begin
                m_k <= m_k + 1;
                if ((m_k + 1 <= m_end) && abort) begin
                    m_run  <= 1'b0;
                    m_busy <= 1'b0;
                end else if (m_k + 1 <= m_end) begin
                    if ((m_k + 1) % D == 0) begin
                        case (((m_k + 1) / D - 1) % 4)
                            0: m_a <= m_b + m_c;
                            1: m_d <= m_a - 32'sd3;
                            2: m_b <= m_d + 32'sd10;
                            default: begin
                                m_c    <= m_c + 32'sd1;
                                m_iter <= m_iter + 4'd1;
                            end
                        endcase
                    end
                end else begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_run  <= 1'b0;
                end
            end else if (start) begin
                m_a <= a_init; m_b <= b_init; m_c <= c_init; m_d <= d_init;
                m_iter <= '0;
                m_k    <= 0;
                m_end  <= 4 * int'(iterations) * D;
                m_busy <= (iterations != 4'd0);
                m_run  <= 1'b1;
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_assert++;
                if ({a, b, c, d, iter_cnt, busy, done} !==
                    {m_a, m_b, m_c, m_d, m_iter, m_busy, m_done}) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t: dut a=%h b=%h c=%h d=%h it=%0d busy=%b done=%b, model a=%h b=%h c=%h d=%h it=%0d busy=%b done=%b",
                             $time, a, b, c, d, iter_cnt, busy, done,
                             m_a, m_b, m_c, m_d, m_iter, m_busy, m_done);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a start from the current (mid-cycle) point; returns at the
    // falling edge after the acceptance edge, which becomes edge 0.
    task automatic run_start(input logic [31:0] ia, input logic [31:0] ib,
                             input logic [31:0] ic, input logic [31:0] id,
                             input logic [3:0] n);
        a_init = ia; b_init = ib; c_init = ic; d_init = id;
        iterations = n;
        start = 1'b1;
        @(posedge clk);
        cur_edge = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic goto(input int e);
        while (cur_edge < e) begin
            @(posedge clk);
            cur_edge++;
        end
        #1;
    endtask

    logic [127:0] exp1 [1:8];

    initial begin
        exp1[1] = {32'd35, 32'd20, 32'd15, 32'd5};
        exp1[2] = {32'd35, 32'd20, 32'd15, 32'd32};
        exp1[3] = {32'd35, 32'd42, 32'd15, 32'd32};
        exp1[4] = {32'd35, 32'd42, 32'd16, 32'd32};
        exp1[5] = {32'd58, 32'd42, 32'd16, 32'd32};
        exp1[6] = {32'd58, 32'd42, 32'd16, 32'd55};
        exp1[7] = {32'd58, 32'd65, 32'd16, 32'd55};
        exp1[8] = {32'd58, 32'd65, 32'd17, 32'd55};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_a", a, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_busy_done_it", {26'd0, busy, done, iter_cnt}, 32'd0);

        // Main run; start on the very first edge after release
        rst_n = 1'b1;
        run_start(32'd30, 32'd20, 32'd15, 32'd5, 4'd4);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        goto(5);  chk("e5_a", a, 32'd35);
        goto(10); chk("e10_d", d, 32'd32);
        goto(15); chk("e15_b", b, 32'd42);
        goto(20); chk("e20_c", c, 32'd16); chk("e20_iter", {28'd0, iter_cnt}, 32'd1);
        goto(80); chk("e80_done", {31'd0, done}, 32'd0);
        // start on the FINISH->IDLE edge must wait a cycle; zero-pass run
        @(negedge clk);
        a_init = 32'd30; b_init = 32'd20; c_init = 32'd15; d_init = 32'd5;
        iterations = 4'd0; start = 1'b1;
        goto(81);
        chk("e81_done", {31'd0, done}, 32'd1);
        chk("e81_busy", {31'd0, busy}, 32'd0);
        chk("fin_a", a, 32'd107); chk("fin_b", b, 32'd114);
        chk("fin_c", c, 32'd19);  chk("fin_d", d, 32'd104);
        chk("fin_iter", {28'd0, iter_cnt}, 32'd4);
        goto(82);
        start = 1'b0;
        chk("zero_busy", {30'd0, busy, done}, 32'd0);
        goto(83);
        chk("zero_done", {30'd0, busy, done}, 32'd1);
        chk("zero_regs", a + b + c + d, 32'd70);

        // Wrap-around
        @(negedge clk);
        run_start(32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'd1);
        goto(5);  chk("ovf_a", a, 32'h8000_0000);
        chk("ovf_a_neg", {31'd0, a[31]}, 32'd1);
        goto(21);
        chk("ovf_done", {31'd0, done}, 32'd1);
        chk("ovf_d", d, 32'h7FFF_FFFD);
        chk("ovf_b", b, 32'h8000_0007);
        chk("ovf_c", c, 32'd2);

        // Abort at edge 27 with an ignored second start at edge 12
        @(negedge clk);
        run_start(32'd30, 32'd20, 32'd15, 32'd5, 4'd4);
        goto(11); @(negedge clk);
        a_init = 32'd99; iterations = 4'd1; start = 1'b1;
        goto(12); @(negedge clk); start = 1'b0;
        goto(26); @(negedge clk); abort = 1'b1;
        goto(27);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_a", a, 32'd58); chk("ab_b", b, 32'd42);
        chk("ab_c", c, 32'd16); chk("ab_d", d, 32'd32);
        chk("ab_iter", {28'd0, iter_cnt}, 32'd1);
        @(negedge clk); abort = 1'b0;
        goto(40); chk("ab_no_done", {30'd0, busy, done}, 32'd0);

        // Abort on a step edge suppresses that step
        @(negedge clk);
        run_start(32'd30, 32'd20, 32'd15, 32'd5, 4'd4);
        goto(29); @(negedge clk); abort = 1'b1;
        goto(30);
        chk("abstep_d", d, 32'd32);
        chk("abstep_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); abort = 1'b0;

        // start and abort together in IDLE: start wins
        @(negedge clk);
        abort = 1'b1;
        run_start(32'd1, 32'd2, 32'd3, 32'd4, 4'd1);
        abort = 1'b0;
        chk("sa_busy", {31'd0, busy}, 32'd1);
        goto(21);
        chk("sa_done", {31'd0, done}, 32'd1);
        chk("sa_a", a, 32'd5); chk("sa_b", b, 32'd12);

        // Asynchronous reset mid-WAIT, then a fresh full run
        @(negedge clk);
        run_start(32'd30, 32'd20, 32'd15, 32'd5, 4'd4);
        goto(12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_regs", a | b | c | d, 32'd0);
        chk("arst_flags", {26'd0, busy, done, iter_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_start(32'd30, 32'd20, 32'd15, 32'd5, 4'd4);
        goto(81);
        chk("rerun_done", {31'd0, done}, 32'd1);
        chk("rerun_a", a, 32'd107);
        chk("rerun_d", d, 32'd104);

        // DELAY=1 instance: updates on edges 1..8, done at edge 9
        @(negedge clk);
        a_init = 32'd30; b_init = 32'd20; c_init = 32'd15; d_init = 32'd5;
        iterations = 4'd2; start1 = 1'b1;
        @(posedge clk);
        cur_edge = 0;
        @(negedge clk);
        start1 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            goto(e);
            n_assert++;
            if ({a1, b1, c1, d1} !== exp1[e]) begin
                n_fail++;
                $display("FAIL d1_edge%0d: got %h, expected %h", e, {a1, b1, c1, d1}, exp1[e]);
            end
        end
        chk("d1_e8_done", {31'd0, done1}, 32'd0);
        goto(9);
        chk("d1_e9_done", {31'd0, done1}, 32'd1);
        chk("d1_iter", {28'd0, iter1}, 32'd2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_recurrence_sequencer
`default_nettype wire
